cvs_input_conditioner: RTL and testbench
========================================

# cvs_input_conditioner

Parametrised successor to the fixed 5-input glue logic in `simple_fpga_cvs`. It synchronises and debounces `N_IN` asynchronous board inputs and flags their edges. It then drives `N_OUT` registered outputs, each running a run-time-selectable function (pass, AND, OR, NOT) over the debounced inputs. It sits between the board I/O pins and the rest of the fabric, in the divided-down 300 MHz oscillator domain.

## Interface
Parameters:
- `N_IN`, 5: number of input channels (1..32).
- `N_OUT`, 4: number of configurable logic outputs (1..16).
- `SYNC_STAGES`, 2: synchroniser flops per input (≥2).
- `TICK_DIV`, 300000: clock cycles per debounce sample tick (≥1).
- `DEBOUNCE_TICKS`, 10: consecutive ticks an input must differ from its stable value before being accepted (≥1).

Ports:
- `clk`, input, 1: single system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in`, input, N_IN: asynchronous raw pins.
- `op`, input, 2*N_OUT: per-output function, as `cvs_pkg::op_e`. Output k uses bits [2k+1:2k].
- `sel_a`, input, N_OUT*SW: operand A index per output, where SW = $clog2(N_IN) (minimum 1).
- `sel_b`, input, N_OUT*SW: operand B index per output. Used by AND and OR only.
- `stable`, output, N_IN: debounced input levels.
- `rise`, output, N_IN: one-cycle pulse when `stable[i]` goes 0→1.
- `fall`, output, N_IN: one-cycle pulse when `stable[i]` goes 1→0.
- `out`, output, N_OUT: registered logic outputs.

## Operation
- Synchroniser: each `in[i]` passes through SYNC_STAGES flops, producing `sync[i]`.
- Tick generator: a counter runs 0..TICK_DIV-1. `tick` is high for the one cycle when the count equals TICK_DIV-1, then the counter wraps to 0. With TICK_DIV=1, `tick` is high on every cycle.
- Per-channel debounce counter `cnt[i]`, width $clog2(DEBOUNCE_TICKS+1):
  - if `sync[i]==stable[i]`: `cnt[i]` ← 0, regardless of tick;
  - else, on tick with `cnt[i]==DEBOUNCE_TICKS-1`: `stable[i]` ← `sync[i]`, `cnt[i]` ← 0;
  - else, on tick: `cnt[i]` ← `cnt[i]`+1;
  - else: hold.
- A glitch that returns to the old level before acceptance clears the counter. No partial credit carries over.
- Edge flags: `rise[i]` and `fall[i]` are registered and asserted for exactly the one cycle after `stable[i]` changes. They are never both high.
- Logic outputs, with A = `stable[sel_a_k]` and B = `stable[sel_b_k]`:
  - OP_PASS: `out[k]` ← A.
  - OP_AND: `out[k]` ← A&B.
  - OP_OR: `out[k]` ← A|B.
  - OP_NOT: `out[k]` ← ~A.
- A select index ≥N_IN reads as 0.
- `op` and `sel` changes take effect on the next clock edge. They are not debounced.

## Timing
- Reset values: synchroniser flops, `stable`, `cnt`, `rise`, `fall`, `out` and the tick counter are all 0. The first `tick` occurs TICK_DIV cycles after `rst` deasserts.
- `out` reflects the configured function one cycle after reset release (e.g. OP_NOT gives 1).
- Input edge to `stable` change: between SYNC_STAGES+(DEBOUNCE_TICKS-1)*TICK_DIV+1 and SYNC_STAGES+DEBOUNCE_TICKS*TICK_DIV cycles. The exact value depends on tick phase.
- `stable` to `rise`/`fall`: 1 cycle.
- `stable` to `out`: 1 cycle.
- Reset asserted mid-debounce aborts the debounce. All state returns to reset values on the same edge, and no edge pulse is emitted.
- Simultaneous changes on several channels are handled independently in the same cycle.

## Structure
- `cvs_pkg`: `typedef enum logic [1:0] {OP_PASS=0, OP_AND=1, OP_OR=2, OP_NOT=3} op_e`, plus the shared select-width function. Shared with `simple_fpga_cvs`.
- Sub-module `cvs_tick_gen` (parameter DIV; ports `clk`, `rst`, `tick`). Reused for `clk_1point5hz`-style dividers.
- Synchroniser, debounce and output logic are generate loops inside `cvs_input_conditioner`.

## Test plan
Bench parameters: N_IN=5, N_OUT=4, SYNC_STAGES=2, TICK_DIV=4, DEBOUNCE_TICKS=3.
- Reset: hold `rst` 3 cycles with `in`=5'b11111. Required: `stable`=0, `rise`=`fall`=0, `out`=0 during reset. `out[k]`=1 one cycle after release for OP_NOT outputs.
- Clean edge: `in[0]` 0→1 and held. Required: `stable[0]`=1 within 11..14 cycles; `rise[0]` high exactly 1 cycle; `fall` stays 0.
- Glitch: `in[2]` high for 6 cycles, then low. Required: `stable[2]` and `rise[2]` remain 0. A subsequent 20-cycle hold is accepted.
- Logic functions: `op`={NOT,OR,AND,PASS} on sel_a=0, sel_b=1; sweep stable[1:0] over 00,01,10,11. Required: `out` = {~A, A|B, A&B, A} one cycle after each `stable` change; sel_a=7 forces A=0.
- Reset mid-debounce: assert `rst` for 1 cycle 9 cycles after the `in[3]` rise. Required: `stable[3]`=0, no `rise[3]`. After release, acceptance takes the full 11..14 cycles again.
- Simultaneous: `in[4:3]` 11→00 together. Required: `fall[4]` and `fall[3]` pulse on the same cycle.

Source files
------------

// File: rtl/cvs_pkg.sv
// Shared definitions for the CVS board glue: logic-output opcodes and select sizing.
package cvs_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_NOT  = 2'd3
  } op_e;

  // Width of an operand index into n channels; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cvs_tick_gen.sv
// Free-running divider: tick is high for one cycle out of every DIV.
module cvs_tick_gen #(
  parameter int DIV = 300000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count, wrapping after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/cvs_input_conditioner.sv
// Synchronise, debounce and edge-flag board inputs, then drive configurable
// PASS/AND/OR/NOT outputs from the debounced levels.
module cvs_input_conditioner
  import cvs_pkg::*;
#(
  parameter int N_IN           = 5,
  parameter int N_OUT          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 300000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_IN-1:0]                  in,
  input  logic [2*N_OUT-1:0]               op,
  input  logic [N_OUT*sel_width(N_IN)-1:0] sel_a,
  input  logic [N_OUT*sel_width(N_IN)-1:0] sel_b,
  output logic [N_IN-1:0]                  stable,
  output logic [N_IN-1:0]                  rise,
  output logic [N_IN-1:0]                  fall,
  output logic [N_OUT-1:0]                 out
);

  localparam int SW   = sel_width(N_IN);
  localparam int PADW = 1 << SW;
  localparam int CNTW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_TICKS - 1);

  logic            tick;
  logic [PADW-1:0] stable_pad;

  cvs_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Zero padding makes out-of-range select indices read as 0.
  assign stable_pad = PADW'(stable);

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNTW-1:0]        cnt_q;
    logic [CNTW-1:0]        cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   dly_q;
    logic                   rise_q;
    logic                   fall_q;

    // Debounce: any agreement with the stable level discards accumulated ticks.
    always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync_q[SYNC_STAGES-1] == stable_q) begin
        cnt_d = '0;
      end else if (!tick) begin
        cnt_d = cnt_q;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[SYNC_STAGES-1];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end

    // Synchroniser, debounce state and edge flags lagging stable by one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
        dly_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], in[i]};
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        dly_q    <= stable_q;
        rise_q   <= stable_q & ~dly_q;
        fall_q   <= ~stable_q & dly_q;
      end
    end

    assign stable[i] = stable_q;
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    logic [SW-1:0] idx_a;
    logic [SW-1:0] idx_b;
    logic          opnd_a;
    logic          opnd_b;
    op_e           op_k;
    logic          out_q;
    logic          out_d;

    assign idx_a  = sel_a[k*SW +: SW];
    assign idx_b  = sel_b[k*SW +: SW];
    assign opnd_a = stable_pad[idx_a];
    assign opnd_b = stable_pad[idx_b];
    assign op_k   = op_e'(op[2*k +: 2]);

    // Selected logic function.
    always_comb begin
      out_d = 1'b0;
      case (op_k)
        OP_PASS: out_d = opnd_a;
        OP_AND:  out_d = opnd_a & opnd_b;
        OP_OR:   out_d = opnd_a | opnd_b;
        OP_NOT:  out_d = ~opnd_a;
        default: out_d = 1'b0;
      endcase
    end

    // Output register.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= 1'b0;
      end else begin
        out_q <= out_d;
      end
    end

    assign out[k] = out_q;
  end

endmodule

// File: tb/tb_cvs_input_conditioner.sv
// Self-checking bench for cvs_input_conditioner with a behavioural reference model.
module tb_cvs_input_conditioner;

  localparam int N_IN           = 5;
  localparam int N_OUT          = 4;
  localparam int SYNC_STAGES    = 2;
  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int SW             = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN-1:0]        in;
  logic [2*N_OUT-1:0]     op;
  logic [N_OUT*SW-1:0]    sel_a;
  logic [N_OUT*SW-1:0]    sel_b;
  logic [N_IN-1:0]        stable;
  logic [N_IN-1:0]        rise;
  logic [N_IN-1:0]        fall;
  logic [N_OUT-1:0]       out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N_IN-1:0]  m_pipe [$];
  int               m_edges;
  int               m_run [N_IN];
  logic [N_IN-1:0]  m_stable;
  logic [N_IN-1:0]  m_prev;
  logic [N_IN-1:0]  m_rise;
  logic [N_IN-1:0]  m_fall;
  logic [N_OUT-1:0] m_out;

  always #5 clk = ~clk;

  cvs_input_conditioner #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC_STAGES),
    .TICK_DIV(TICK_DIV), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .op(op), .sel_a(sel_a), .sel_b(sel_b),
    .stable(stable), .rise(rise), .fall(fall), .out(out)
  );

  function automatic logic [N_OUT-1:0] model_out(input logic [N_IN-1:0] s);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int k = 0; k < N_OUT; k++) begin
      int code, ia, ib;
      logic a, b;
      code = int'(op[2*k +: 2]);
      ia   = int'(sel_a[k*SW +: SW]);
      ib   = int'(sel_b[k*SW +: SW]);
      a    = (ia < N_IN) ? s[ia] : 1'b0;
      b    = (ib < N_IN) ? s[ib] : 1'b0;
      case (code)
        0:       r[k] = a;
        1:       r[k] = a & b;
        2:       r[k] = a | b;
        default: r[k] = ~a;
      endcase
    end
    return r;
  endfunction

  // One clock edge of the spec's behaviour, from the inputs currently applied.
  task automatic model_edge();
    logic [N_IN-1:0] sync;
    bit tick;
    if (rst) begin
      m_pipe.delete();
      for (int s = 0; s < SYNC_STAGES; s++) m_pipe.push_back('0);
      m_edges  = 0;
      for (int i = 0; i < N_IN; i++) m_run[i] = 0;
      m_stable = '0; m_prev = '0; m_rise = '0; m_fall = '0; m_out = '0;
    end else begin
      sync = m_pipe.pop_front();
      m_pipe.push_back(in);
      tick = ((m_edges % TICK_DIV) == TICK_DIV - 1);
      m_edges++;
      m_rise = m_stable & ~m_prev;
      m_fall = ~m_stable & m_prev;
      m_out  = model_out(m_stable);
      m_prev = m_stable;
      for (int i = 0; i < N_IN; i++) begin
        if (sync[i] == m_stable[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE_TICKS) begin
            m_stable[i] = sync[i];
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in = '1;
    op = {2'd3, 2'd2, 2'd1, 2'd0};
    sel_a = '0; sel_b = {4{3'd1}};
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (stable !== 5'b0 || rise !== 5'b0 || fall !== 5'b0 || out !== 4'b0) begin
        errors++;
        $display("FAIL reset_state: stable=%b rise=%b fall=%b out=%b, need all 0", stable, rise, fall, out);
      end
    end
    rst = 1'b0; in = '0;
    step();
    checks++;
    if (out !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release_out: got %b need 1000", out);
    end
  endtask

  task automatic test_clean_edge();
    int k = 0;
    repeat ($urandom_range(0, 3)) step();
    in[0] = 1'b1;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step();
      if (stable[0] === 1'b1) k = c;
      else if (fall !== 5'b0) begin
        checks++; errors++;
        $display("FAIL clean_fall: fall=%b need 00000", fall);
      end
    end
    checks++;
    if (k < 11 || k > 14) begin
      errors++;
      $display("FAIL clean_latency: got %0d cycles need 11..14", k);
    end
    step();
    checks++;
    if (rise[0] !== 1'b1 || fall !== 5'b0) begin
      errors++;
      $display("FAIL clean_rise: rise=%b fall=%b need rise[0]=1 fall=0", rise, fall);
    end
    step();
    checks++;
    if (rise[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_rise_width: rise[0]=%b need 0", rise[0]);
    end
    checks++;
    if (stable !== m_stable) begin
      errors++;
      $display("FAIL clean_model: stable=%b need %b", stable, m_stable);
    end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    int rises = 0;
    in[2] = 1'b1;
    repeat (6) begin step(); seen |= rise[2] | stable[2]; end
    in[2] = 1'b0;
    repeat (20) begin step(); seen |= rise[2] | stable[2]; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: stable/rise[2] seen=%b need 0", seen);
    end
    in[2] = 1'b1;
    repeat (20) begin step(); if (rise[2] === 1'b1) rises++; end
    checks++;
    if (stable[2] !== 1'b1 || rises != 1) begin
      errors++;
      $display("FAIL glitch_accept: stable[2]=%b rises=%0d need 1 and 1", stable[2], rises);
    end
  endtask

  task automatic test_logic();
    logic [1:0] t;
    logic a, b;
    for (int p = 0; p < 4; p++) begin
      t = 2'(p);
      a = t[0]; b = t[1];
      in[1:0] = t;
      for (int c = 0; c < 30 && stable[1:0] !== t; c++) step();
      checks++;
      if (stable[1:0] !== t) begin
        errors++;
        $display("FAIL logic_settle: stable[1:0]=%b need %b", stable[1:0], t);
      end
      step();
      checks++;
      if (out !== {~a, a | b, a & b, a}) begin
        errors++;
        $display("FAIL logic_out: pattern %b got %b need %b", t, out, {~a, a | b, a & b, a});
      end
      sel_a = {4{3'd7}};
      step();
      checks++;
      if (out !== {1'b1, b, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL logic_sel_oob: pattern %b got %b need %b", t, out, {1'b1, b, 1'b0, 1'b0});
      end
      sel_a = '0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic early_rise = 1'b0;
    in[3] = 1'b1;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (stable[3] !== 1'b0 || rise[3] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: stable[3]=%b rise[3]=%b need 0 0", stable[3], rise[3]);
    end
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step();
      if (stable[3] === 1'b1) k = c;
      else early_rise |= rise[3];
    end
    checks++;
    if (k < 11 || k > 14 || early_rise !== 1'b0) begin
      errors++;
      $display("FAIL midreset_latency: got %0d cycles early_rise=%b need 11..14 and 0", k, early_rise);
    end
    step();
    checks++;
    if (rise[3] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rise: rise[3]=%b need 1", rise[3]);
    end
  endtask

  task automatic test_simultaneous();
    in[4:3] = 2'b11;
    for (int c = 0; c < 30 && stable[4:3] !== 2'b11; c++) step();
    repeat (3) step();
    in[4:3] = 2'b00;
    for (int c = 0; c < 30 && fall[4:3] === 2'b00; c++) step();
    checks++;
    if (fall[4:3] !== 2'b11 || rise !== 5'b0) begin
      errors++;
      $display("FAIL simul_fall: fall=%b rise=%b need fall[4:3]=11 rise=0", fall, rise);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) in[$urandom_range(0, N_IN - 1)] ^= 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom; op = r[7:0];
        r = $urandom; sel_a = r[11:0];
        r = $urandom; sel_b = r[11:0];
      end
      rst = ($urandom_range(0, 249) == 0);
      step();
      checks++;
      if (stable !== m_stable || rise !== m_rise || fall !== m_fall || out !== m_out) begin
        errors++;
        $display("FAIL rand_cycle %0d: stable=%b rise=%b fall=%b out=%b need %b %b %b %b",
                 c, stable, rise, fall, out, m_stable, m_rise, m_fall, m_out);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_logic();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
